// File: rtl/ascon_perm_ctrl.sv
// Round sequencer for the iterative ASCON permutation datapath.
// It drives the state-register enable, the input-mux select and the round-constant index.
module ascon_perm_ctrl #(
    parameter int UNROLL = 1
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [1:0] nrounds_i,
    input  logic       abort_i,
    input  logic       res_ready_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       state_en_o,
    output logic       state_sel_o,
    output logic [3:0] round_o,
    output logic       res_valid_o
);

    if (UNROLL != 1 && UNROLL != 2) begin : gBadUnroll
        $error("ascon_perm_ctrl: UNROLL must be 1 or 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [3:0] STEP      = 4'(UNROLL);
    localparam logic [3:0] LAST_CNT  = 4'd12;

    state_t     state_q, state_d;
    logic [3:0] roundCnt_q, roundCnt_d;
    logic       first_q, first_d;
    logic [3:0] nextCnt;

    // Shorter permutations start part-way into the 12-entry constant table.
    function automatic logic [3:0] startRound(input logic [1:0] nr);
        case (nr)
            2'b01:   startRound = 4'd4;
            2'b10:   startRound = 4'd6;
            default: startRound = 4'd0;
        endcase
    endfunction

    assign nextCnt = roundCnt_q + STEP;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            roundCnt_q <= 4'd0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            roundCnt_q <= roundCnt_d;
            first_q    <= first_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        roundCnt_d = roundCnt_q;
        first_d    = first_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = RUN;
                    roundCnt_d = startRound(nrounds_i);
                    first_d    = 1'b1;
                end
            end
            RUN: begin
                roundCnt_d = nextCnt;
                first_d    = 1'b0;
                if (nextCnt == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    if (start_i) begin
                        state_d    = RUN;
                        roundCnt_d = startRound(nrounds_i);
                        first_d    = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        roundCnt_d = 4'd0;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                roundCnt_d = 4'd0;
                first_d    = 1'b0;
            end
        endcase
        if (abort_i) begin
            state_d    = IDLE;
            roundCnt_d = 4'd0;
            first_d    = 1'b0;
        end
    end

    // Abort must keep the state register frozen in the very cycle it is raised.
    assign state_en_o  = (state_q == RUN) && !abort_i;
    assign state_sel_o = (state_q == RUN) && first_q;
    assign round_o     = (state_q == RUN) ? roundCnt_q : 4'd0;
    assign res_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign ready_o     = (state_q == IDLE) || ((state_q == DONE) && res_ready_i);

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Scoreboard bench for ascon_perm_ctrl: one instance with UNROLL=1 and one with UNROLL=2.
// Expected round indices are queued when a permutation is launched and popped on every enable cycle.
module tb_ascon_perm_ctrl;

    logic       clock;
    logic       reset;
    logic       start    [2];
    logic [1:0] nrounds  [2];
    logic       abort    [2];
    logic       resReady [2];
    logic       ready    [2];
    logic       busy     [2];
    logic       stateEn  [2];
    logic       stateSel [2];
    logic [3:0] roundO   [2];
    logic       resValid [2];

    int checkCount = 0;
    int passCount  = 0;
    int expQ0[$];
    int expQ1[$];
    int e0;
    int e1;

    ascon_perm_ctrl #(.UNROLL(1)) u1 (
        .clock_i(clock), .reset_i(reset), .start_i(start[0]), .nrounds_i(nrounds[0]),
        .abort_i(abort[0]), .res_ready_i(resReady[0]), .ready_o(ready[0]), .busy_o(busy[0]),
        .state_en_o(stateEn[0]), .state_sel_o(stateSel[0]), .round_o(roundO[0]),
        .res_valid_o(resValid[0])
    );

    ascon_perm_ctrl #(.UNROLL(2)) u2 (
        .clock_i(clock), .reset_i(reset), .start_i(start[1]), .nrounds_i(nrounds[1]),
        .abort_i(abort[1]), .res_ready_i(resReady[1]), .ready_o(ready[1]), .busy_o(busy[1]),
        .state_en_o(stateEn[1]), .state_sel_o(stateSel[1]), .round_o(roundO[1]),
        .res_valid_o(resValid[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Each queued entry holds the round index in bits 3:0 and the expected select in bit 4.
    task automatic pushRounds(input int u, input int firstRound, input int count, input int step);
        for (int i = 0; i < count; i++) begin
            int v;
            v = firstRound + i * step;
            if (i == 0) v = v | 16;
            if (u == 0) expQ0.push_back(v);
            else expQ1.push_back(v);
        end
    endtask

    task automatic applyStimulus(input int u, input logic [1:0] nr, input int firstRound,
                                 input int count, input int step);
        start[u]   = 1'b1;
        nrounds[u] = nr;
        pushRounds(u, firstRound, count, step);
        tick();
        start[u]   = 1'b0;
        nrounds[u] = ~nr;
    endtask

    task automatic waitValid(input int u, input int expLat);
        int lat;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (resValid[u]) break;
            lat++;
        end
        checkOutput($sformatf("u%0d latency", u + 1), lat, expLat);
        checkOutput($sformatf("u%0d leftover rounds", u + 1),
                    (u == 0) ? expQ0.size() : expQ1.size(), 0);
    endtask

    task automatic releaseResult(input int u);
        tick();
        resReady[u] = 1'b1;
        tick();
        resReady[u] = 1'b0;
        @(negedge clock);
        checkOutput($sformatf("u%0d idle after release", u + 1), busy[u], 0);
        checkOutput($sformatf("u%0d valid after release", u + 1), resValid[u], 0);
    endtask

    always @(negedge clock) begin
        if (stateEn[0]) begin
            if (expQ0.size() == 0) checkOutput("u1 enable unexpected", stateEn[0], 0);
            else begin
                e0 = expQ0.pop_front();
                checkOutput("u1 round", roundO[0], e0 & 15);
                checkOutput("u1 sel", stateSel[0], e0 >> 4);
            end
        end
    end

    always @(negedge clock) begin
        if (stateEn[1]) begin
            if (expQ1.size() == 0) checkOutput("u2 enable unexpected", stateEn[1], 0);
            else begin
                e1 = expQ1.pop_front();
                checkOutput("u2 round", roundO[1], e1 & 15);
                checkOutput("u2 sel", stateSel[1], e1 >> 4);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global timeout: got 1, expected 0");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start[u]    = 1'b0;
            nrounds[u]  = 2'b00;
            abort[u]    = 1'b0;
            resReady[u] = 1'b0;
        end
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            checkOutput("reset ready", ready[u], 1);
            checkOutput("reset busy", busy[u], 0);
            checkOutput("reset en", stateEn[u], 0);
            checkOutput("reset sel", stateSel[u], 0);
            checkOutput("reset round", roundO[u], 0);
            checkOutput("reset valid", resValid[u], 0);
        end
        tick();

        // p12 with single-round datapath; nrounds is scrambled after accept
        applyStimulus(0, 2'b00, 0, 12, 1);
        waitValid(0, 12);
        releaseResult(0);

        // p6 with the result held back while start is hammered
        tick();
        applyStimulus(0, 2'b10, 6, 6, 1);
        waitValid(0, 6);
        tick();
        start[0] = 1'b1;
        nrounds[0] = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("hold valid", resValid[0], 1);
            checkOutput("hold ready", ready[0], 0);
            checkOutput("hold busy", busy[0], 1);
            tick();
        end
        start[0] = 1'b0;
        resReady[0] = 1'b1;
        tick();
        resReady[0] = 1'b0;
        @(negedge clock);
        checkOutput("hold release busy", busy[0], 0);
        checkOutput("hold release ready", ready[0], 1);
        checkOutput("hold release valid", resValid[0], 0);

        // back-to-back: accept p8 straight out of DONE
        tick();
        applyStimulus(0, 2'b10, 6, 6, 1);
        waitValid(0, 6);
        tick();
        resReady[0] = 1'b1;
        start[0] = 1'b1;
        nrounds[0] = 2'b01;
        pushRounds(0, 4, 8, 1);
        @(negedge clock);
        checkOutput("b2b ready in done", ready[0], 1);
        tick();
        start[0] = 1'b0;
        resReady[0] = 1'b0;
        nrounds[0] = 2'b10;
        waitValid(0, 8);
        releaseResult(0);

        // abort together with start while at round 7
        tick();
        applyStimulus(0, 2'b00, 0, 7, 1);
        repeat (7) tick();
        abort[0] = 1'b1;
        start[0] = 1'b1;
        @(negedge clock);
        checkOutput("abort cycle en", stateEn[0], 0);
        tick();
        abort[0] = 1'b0;
        start[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("abort busy", busy[0], 0);
            checkOutput("abort valid", resValid[0], 0);
            checkOutput("abort ready", ready[0], 1);
            tick();
        end
        checkOutput("abort leftover rounds", expQ0.size(), 0);

        // synchronous reset while at round 5
        applyStimulus(0, 2'b00, 0, 6, 1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        checkOutput("midrun reset busy", busy[0], 0);
        checkOutput("midrun reset en", stateEn[0], 0);
        checkOutput("midrun reset valid", resValid[0], 0);
        checkOutput("midrun reset round", roundO[0], 0);
        checkOutput("midrun reset ready", ready[0], 1);
        checkOutput("midrun reset leftover", expQ0.size(), 0);
        tick();

        // two-rounds-per-clock datapath: reserved code, p6 and p8
        applyStimulus(1, 2'b11, 0, 6, 2);
        waitValid(1, 6);
        releaseResult(1);
        tick();
        applyStimulus(1, 2'b10, 6, 3, 2);
        waitValid(1, 3);
        releaseResult(1);
        tick();
        applyStimulus(1, 2'b01, 4, 4, 2);
        waitValid(1, 4);
        releaseResult(1);

        repeat (2) tick();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
